// File: rtl/line_matrix3x3_gen.sv
// Streams a raster through two line buffers and emits a 3-row column (r-2, r-1, r) per beat, 2-cycle latency.
// Optional build macro: LINE_MATRIX_ZERO_FILL_EN zeroes rows not yet filled in the current frame.
module line_matrix3x3_gen #(
    parameter int DATA_WIDTH = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [DATA_WIDTH-1:0] matrix0_tdata,
    output logic [DATA_WIDTH-1:0] matrix1_tdata,
    output logic [DATA_WIDTH-1:0] matrix2_tdata
);

    localparam int               STAGES   = 2;
    localparam int               COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    // IMG_HEIGHT drives no logic; it is only sanity-checked at elaboration.
    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_size
        $error("line_matrix3x3_gen: image dimensions must be positive");
    end

    typedef struct packed {
        logic last;
        logic user;
    } sband_t;

    logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

    logic [COL_W-1:0]      col, beat_col;
    logic [1:0]            rows, beat_rows, rows_inc;
    logic                  line_end;

    logic [STAGES:1]       vld_pipe;
    sband_t                sb_in, sb_q1, sb_q2;
    logic [DATA_WIDTH-1:0] tap0_q, tap1_q, pix_q;
    logic [DATA_WIDTH-1:0] tap0_fill, tap1_fill;

    // Start of frame overrides the running position before the beat is used.
    always_comb begin
        beat_col  = s_axis_tuser ? '0 : col;
        beat_rows = s_axis_tuser ? 2'd0 : rows;
        line_end  = s_axis_tlast || (beat_col == COL_LAST);
        rows_inc  = (beat_rows == 2'd2) ? 2'd2 : beat_rows + 2'd1;
    end

    assign sb_in = '{last: s_axis_tvalid & s_axis_tlast, user: s_axis_tvalid & s_axis_tuser};

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            rows <= 2'd0;
        end else if (s_axis_tvalid) begin
            col  <= line_end ? '0 : beat_col + 1'b1;
            rows <= line_end ? rows_inc : beat_rows;
        end
    end

    // Buffer contents survive reset; the read in the stage-1 block sees pre-write data.
    always_ff @(posedge pixel_clk) begin
        if (s_axis_tvalid) begin
            lb0[beat_col] <= lb1[beat_col];
            lb1[beat_col] <= s_axis_tdata;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sb_q1    <= '0;
            sb_q2    <= '0;
            tap0_q   <= '0;
            tap1_q   <= '0;
            pix_q    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], s_axis_tvalid};
            sb_q1    <= sb_in;
            sb_q2    <= sb_q1;
            if (s_axis_tvalid) begin
                tap0_q <= lb0[beat_col];
                tap1_q <= lb1[beat_col];
                pix_q  <= s_axis_tdata;
            end
        end
    end

`ifdef LINE_MATRIX_ZERO_FILL_EN
    logic [1:0] rows_q;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)
            rows_q <= 2'd0;
        else if (s_axis_tvalid)
            rows_q <= beat_rows;
    end

    assign tap1_fill = (rows_q < 2'd1) ? '0 : tap1_q;
    assign tap0_fill = (rows_q < 2'd2) ? '0 : tap0_q;
`else
    assign tap1_fill = tap1_q;
    assign tap0_fill = tap0_q;
`endif

    // Matrix outputs only move on valid slots and hold through bubbles.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix0_tdata <= '0;
            matrix1_tdata <= '0;
            matrix2_tdata <= '0;
        end else if (vld_pipe[1]) begin
            matrix0_tdata <= tap0_fill;
            matrix1_tdata <= tap1_fill;
            matrix2_tdata <= pix_q;
        end
    end

    assign m_axis_tvalid = vld_pipe[STAGES];
    assign m_axis_tlast  = sb_q2.last;
    assign m_axis_tuser  = sb_q2.user;

endmodule

// File: tb/tb_line_matrix3x3_gen.sv
// Directed bench for line_matrix3x3_gen on an 8-pixel-wide raster, pixel = row*16 + col.
module tb_line_matrix3x3_gen;

    localparam int DW = 10;
    localparam int IW = 8;
`ifdef LINE_MATRIX_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          pixel_clk = 1'b0;
    logic          rst_n     = 1'b0;
    logic          tv = 1'b0, tl = 1'b0, tu = 1'b0;
    logic [DW-1:0] td = '0;
    logic          m_tvalid, m_tlast, m_tuser;
    logic [DW-1:0] m0, m1, m2;

    line_matrix3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(4)) dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (tv),
        .s_axis_tlast  (tl),
        .s_axis_tuser  (tu),
        .s_axis_tdata  (td),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .matrix0_tdata (m0),
        .matrix1_tdata (m1),
        .matrix2_tdata (m2)
    );

    always #5 pixel_clk = ~pixel_clk;

    // One record per input cycle; the expectation applies to the output two cycles later.
    typedef struct {
        logic          v, l, u;
        logic [DW-1:0] d;
        logic          ck, ev, el, eu;
        logic          c0, c1, c2;
        logic [DW-1:0] e0, e1, e2;
    } vec_t;

    vec_t vecs[$];
    vec_t hist0, hist1;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   step_no = 0;

    function automatic vec_t idle_vec();
        vec_t x;
        x = '{default: '0};
        x.ck = 1'b1;
        x.c0 = 1'b1;
        x.c1 = 1'b1;
        x.c2 = 1'b1;
        return x;
    endfunction

    function automatic void add_beat(input logic l, input logic u, input int d,
                                     input logic c0, input int e0, input logic c1, input int e1);
        vec_t x;
        x    = '{default: '0};
        x.v  = 1'b1;  x.l  = l;  x.u  = u;  x.d  = DW'(d);
        x.ck = 1'b1;  x.ev = 1'b1;  x.el = l;  x.eu = u;
        x.c0 = c0;    x.e0 = DW'(e0);
        x.c1 = c1;    x.e1 = DW'(e1);
        x.c2 = 1'b1;  x.e2 = DW'(d);
        vecs.push_back(x);
    endfunction

    // Bubble: no beat, flags driven to check the AND with tvalid, matrices expected held.
    function automatic void add_bubble(input logic l, input logic u);
        vec_t x;
        x    = vecs[$];
        x.v  = 1'b0;  x.l  = l;  x.u  = u;  x.d  = '1;
        x.ev = 1'b0;  x.el = 1'b0;  x.eu = 1'b0;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, step_no, act, exp);
        end
    endtask

    task automatic step(input vec_t x);
        if (hist1.ck) begin
            chk("m_axis_tvalid", int'(m_tvalid), int'(hist1.ev));
            chk("m_axis_tlast", int'(m_tlast), int'(hist1.el));
            chk("m_axis_tuser", int'(m_tuser), int'(hist1.eu));
            if (hist1.c2) chk("matrix2", int'(m2), int'(hist1.e2));
            if (hist1.c1) chk("matrix1", int'(m1), int'(hist1.e1));
            if (hist1.c0) chk("matrix0", int'(m0), int'(hist1.e0));
        end
        hist1 = hist0;
        hist0 = x;
        tv = x.v;  tl = x.l;  tu = x.u;  td = x.d;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        step_no++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tvalid"}, int'(m_tvalid), 0);
        chk({tag, "_tlast"},  int'(m_tlast),  0);
        chk({tag, "_tuser"},  int'(m_tuser),  0);
        chk({tag, "_matrix0"}, int'(m0), 0);
        chk({tag, "_matrix1"}, int'(m1), 0);
        chk({tag, "_matrix2"}, int'(m2), 0);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        // Table: idle after reset, frame 1, frame 2 with bubbles, untagged rows, implicit wrap, tuser+tlast.
        vecs.push_back(idle_vec());
        vecs.push_back(idle_vec());
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IW; c++) begin
                p = r * 16 + c;
                add_beat(c == IW - 1, r == 0 && c == 0, p,
                         (r >= 2) || ZF, (r >= 2) ? p - 32 : 0,
                         (r >= 1) || ZF, (r >= 1) ? p - 16 : 0);
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < IW; c++) begin
                p = r * 16 + c;
                add_beat(c == IW - 1, r == 0 && c == 0, p,
                         1'b1, (r >= 2) ? p - 32 : (ZF ? 0 : ((r == 1) ? 48 + c : 32 + c)),
                         1'b1, (r >= 1) ? p - 16 : (ZF ? 0 : 48 + c));
                add_bubble(1'b1, 1'b1);
            end
        for (int c = 0; c < IW; c++) add_beat(c == IW - 1, 1'b0, 64 + c, 1'b1, 32 + c, 1'b1, 48 + c);
        for (int c = 0; c < IW; c++) add_beat(1'b0, 1'b0, 80 + c, 1'b1, 48 + c, 1'b1, 64 + c);
        add_beat(1'b0, 1'b0, 100, 1'b1, 64, 1'b1, 80);
        add_beat(1'b1, 1'b1, 200, 1'b1, ZF ? 0 : 80, 1'b1, ZF ? 0 : 100);
        add_beat(1'b0, 1'b0, 201, 1'b1, ZF ? 0 : 100, 1'b1, 200);
        for (int i = 0; i < 3; i++) add_bubble(1'b0, 1'b0);

        hist0 = idle_vec();
        hist1 = idle_vec();
        #3;
        chk_all_zero("reset");
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst_n = 1'b1;
        run_vecs();

        // Mid-line reset: row0 full, row1 cols 0..3, then reset while col 4 is presented.
        vecs.delete();
        for (int c = 0; c < IW; c++) add_beat(c == IW - 1, c == 0, c, 1'b0, 0, 1'b0, 0);
        for (int c = 0; c < 4; c++) add_beat(1'b0, 1'b0, 16 + c, ZF, 0, 1'b1, c);
        run_vecs();
        tv = 1'b1;  tl = 1'b0;  tu = 1'b0;  td = DW'(20);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        tv = 1'b0;
        @(posedge pixel_clk);
        #1 chk_all_zero("held_reset");
        @(negedge pixel_clk);
        rst_n = 1'b1;
        hist0 = idle_vec();
        hist1 = idle_vec();
        vecs.delete();
        add_beat(1'b0, 1'b0, 300, 1'b1, 0, 1'b1, ZF ? 0 : 16);
        add_beat(1'b1, 1'b0, 301, 1'b1, ZF ? 0 : 1, 1'b1, ZF ? 0 : 17);
        add_beat(1'b0, 1'b0, 302, 1'b1, ZF ? 0 : 16, 1'b1, 300);
        for (int i = 0; i < 3; i++) add_bubble(1'b0, 1'b0);
        run_vecs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
